// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the AXI DMA read-address path.
package axi_dma_pkg;

    // Read-address generator states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ADDR  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // AXI AxBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // AXI bursts may not cross this boundary
    localparam int PAGE_BYTES = 4096;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst length: the smallest of beats remaining, the burst cap
// and the beats left before the next 4KB page boundary.
module axi_burst_calc
    import axi_dma_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int MAX_LEN    = 16,
    parameter int BEAT_BYTES = 4
) (
    input  logic [11:0]      addr,
    input  logic [CNT_W-1:0] remaining,
    output logic [8:0]       len
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    // Wide enough for both the page-beat count (13 bits) and the remaining count
    localparam int CW = (CNT_W > 13) ? CNT_W : 13;

    logic [12:0]   page_bytes;
    logic [CW-1:0] page_beats;
    logic [CW-1:0] rem_ext;

    // Address is beat-aligned, so the page remainder divides exactly
    assign page_bytes = 13'(PAGE_BYTES) - {1'b0, addr};
    assign page_beats = CW'(page_bytes >> BEAT_SHIFT);
    assign rem_ext    = CW'(remaining);

    // Clamp to the burst cap, then to the page limit, then to what is left
    always_comb begin
        len = 9'(MAX_LEN);
        if (page_beats < CW'(len)) begin
            len = page_beats[8:0];
        end
        if (rem_ext < CW'(len)) begin
            len = rem_ext[8:0];
        end
    end

endmodule

// File: rtl/axi_raddr_gen.sv
// AXI read-address generator: splits a DMA transfer into INCR bursts that
// respect the burst cap and 4KB pages, and throttles on outstanding bursts.
module axi_raddr_gen
    import axi_dma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 14,
    parameter int MAX_LEN    = 16,
    parameter int BEAT_BYTES = 4,
    parameter int MAX_OUTS   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic              dma_axi_start,
    input  logic [ADDR_W-1:0] dma_cfg_saddr,
    input  logic [CNT_W-1:0]  dma_cfg_number,
    input  logic              rburst_done,
    output logic              dma_axi_raddr_free,
    output logic              dma_axi_raddr_done
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int OUT_W      = $clog2(MAX_OUTS + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTS);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    state_t            state_reg,     state_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [7:0]        arlen_reg,     arlen_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [OUT_W-1:0]  outs_reg,      outs_next;
    logic              arvalid_reg,   arvalid_next;
    logic              free_reg,      free_next;
    logic              done_reg,      done_next;

    logic [8:0]        calc_len;
    logic              handshake;
    logic              resp_dec;
    logic [ADDR_W-1:0] addr_step;
    logic [CNT_W-1:0]  rem_after;

    axi_burst_calc #(
        .CNT_W      (CNT_W),
        .MAX_LEN    (MAX_LEN),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_calc (
        .addr      (addr_reg[11:0]),
        .remaining (remaining_reg),
        .len       (calc_len)
    );

    assign handshake = arvalid_reg & arready;
    // A completion with nothing outstanding is spurious and dropped
    assign resp_dec  = rburst_done & (outs_reg != '0);
    // Burst size in bytes and beats, recovered from the registered arlen
    assign addr_step = (ADDR_W'(arlen_reg) + ADDR_W'(1)) << BEAT_SHIFT;
    assign rem_after = remaining_reg - (CNT_W'(arlen_reg) + CNT_W'(1));

    // Next-state and next-output logic for the burst sequencer
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        arlen_next     = arlen_reg;
        remaining_next = remaining_reg;
        arvalid_next   = arvalid_reg;
        free_next      = free_reg;
        done_next      = 1'b0;
        outs_next      = outs_reg;

        // Outstanding-burst accounting; coincident issue and completion cancel
        case ({handshake, resp_dec})
            2'b10:   outs_next = outs_reg + OUT_ONE;
            2'b01:   outs_next = outs_reg - OUT_ONE;
            default: outs_next = outs_reg;
        endcase

        case (state_reg)
            IDLE: begin
                if (dma_axi_start) begin
                    addr_next      = dma_cfg_saddr & ALIGN_MASK;
                    remaining_next = dma_cfg_number;
                    free_next      = 1'b0;
                    state_next     = (dma_cfg_number == '0) ? DRAIN : CALC;
                end
            end
            CALC: begin
                if (outs_reg < OUT_MAX) begin
                    arlen_next   = 8'(calc_len - 9'd1);
                    arvalid_next = 1'b1;
                    state_next   = ADDR;
                end
            end
            ADDR: begin
                if (handshake) begin
                    addr_next      = addr_reg + addr_step;
                    remaining_next = rem_after;
                    arvalid_next   = 1'b0;
                    state_next     = (rem_after == '0) ? DRAIN : CALC;
                end
            end
            DRAIN: begin
                if ((outs_reg == '0) || ((outs_reg == OUT_ONE) && rburst_done)) begin
                    done_next  = 1'b1;
                    free_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            arlen_reg     <= '0;
            remaining_reg <= '0;
            outs_reg      <= '0;
            arvalid_reg   <= 1'b0;
            free_reg      <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            arlen_reg     <= arlen_next;
            remaining_reg <= remaining_next;
            outs_reg      <= outs_next;
            arvalid_reg   <= arvalid_next;
            free_reg      <= free_next;
            done_reg      <= done_next;
        end
    end

    assign araddr             = addr_reg;
    assign arlen              = arlen_reg;
    assign arsize             = 3'(BEAT_SHIFT);
    assign arburst            = BURST_INCR;
    assign arvalid            = arvalid_reg;
    assign dma_axi_raddr_free = free_reg;
    assign dma_axi_raddr_done = done_reg;

endmodule

// File: tb/tb_axi_raddr_gen.sv
// Scoreboard bench for axi_raddr_gen: expected AR bursts are queued by the
// stimulus and checked by a monitor at every AR handshake.
module tb_axi_raddr_gen;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        dma_axi_start = 1'b0;
    logic [31:0] dma_cfg_saddr = '0;
    logic [13:0] dma_cfg_number = '0;
    logic        rburst_done;
    logic        free;
    logic        done;
    logic        auto_pulse = 1'b0;
    logic        man_pulse = 1'b0;

    assign rburst_done = auto_pulse | man_pulse;

    always #5 aclk = ~aclk;

    axi_raddr_gen #(
        .ADDR_W     (32),
        .CNT_W      (14),
        .MAX_LEN    (16),
        .BEAT_BYTES (4),
        .MAX_OUTS   (2)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .araddr             (araddr),
        .arlen              (arlen),
        .arsize             (arsize),
        .arburst            (arburst),
        .arvalid            (arvalid),
        .arready            (arready),
        .dma_axi_start      (dma_axi_start),
        .dma_cfg_saddr      (dma_cfg_saddr),
        .dma_cfg_number     (dma_cfg_number),
        .rburst_done        (rburst_done),
        .dma_axi_raddr_free (free),
        .dma_axi_raddr_done (done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t  exp_q[$];
    int   hs_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   rb_seen = 0;
    int   done_count = 0;
    int   done_cyc = 0;
    int   last_rb_cyc = 0;
    int   start_cyc = 0;
    bit   auto_rb = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic expect_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [13:0] n);
        step();
        dma_cfg_saddr  = a;
        dma_cfg_number = n;
        dma_axi_start  = 1'b1;
        @(negedge aclk);
        start_cyc = cyc;
        step();
        dma_axi_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int k;
        d0 = done_count;
        k  = 0;
        while (done_count == d0 && k < budget) begin
            @(negedge aclk);
            #1;
            k++;
        end
        n_cmp++;
        if (done_count == d0) begin
            n_err++;
            $display("FAIL %s: no done within %0d cycles, required a done pulse", name, budget);
        end
    endtask

    task automatic wait_arvalid(input string name, input int budget);
        int k;
        k = 0;
        @(negedge aclk);
        #1;
        while (!arvalid && k < budget) begin
            @(negedge aclk);
            #1;
            k++;
        end
        chk(name, 32'(arvalid), 32'd1);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        areset = 1'b1;
        #2 areset = 1'b0;

        fork
            // Cycle counter
            forever begin
                @(posedge aclk);
                cyc++;
            end
            // Read-side responder: one completion per issued burst
            forever begin
                @(posedge aclk);
                #1;
                if (auto_rb && !auto_pulse && hs_count > rb_seen) auto_pulse = 1'b1;
                else auto_pulse = 1'b0;
            end
            // Monitor: scoreboard of AR handshakes, hold checks, done tracking
            begin : mon
                ar_t         e;
                int          endb;
                logic        prev_stall;
                logic        prev_done;
                logic [31:0] prev_addr;
                logic [7:0]  prev_len;
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                prev_addr  = '0;
                prev_len   = '0;
                forever begin
                    @(negedge aclk);
                    if (!areset) begin
                        prev_stall = 1'b0;
                        prev_done  = 1'b0;
                    end else begin
                        if (prev_stall && arvalid) begin
                            chk("hold_araddr", araddr, prev_addr);
                            chk("hold_arlen", 32'(arlen), 32'(prev_len));
                        end
                        if (arvalid && arready) begin
                            hs_count++;
                            hs_cyc.push_back(cyc);
                            $display("AR cycle=%0d araddr=0x%08h arlen=%0d", cyc, araddr, arlen);
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL ar_unexpected: got burst 0x%08h/%0d, required none", araddr, arlen);
                            end else begin
                                e = exp_q.pop_front();
                                chk("araddr", araddr, e.addr);
                                chk("arlen", 32'(arlen), 32'(e.len));
                                endb = int'(araddr[11:0]) + (int'(arlen) + 1) * 4;
                                chk("page_cross_ok", 32'(endb <= 4096), 32'd1);
                            end
                        end
                        prev_stall = arvalid && !arready;
                        prev_addr  = araddr;
                        prev_len   = arlen;
                        if (rburst_done) begin
                            rb_seen++;
                            last_rb_cyc = cyc;
                        end
                        if (done) begin
                            done_count++;
                            done_cyc = cyc;
                            $display("DONE cycle=%0d", cyc);
                            if (prev_done) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL done_width: got done high 2+ cycles, required 1");
                            end
                        end
                        prev_done = done;
                    end
                end
            end
        join_none

        // Reset state, sampled while reset is held
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arlen", 32'(arlen), 32'h0);
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_free", 32'(free), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        step();
        areset = 1'b1;

        // 40 beats from 0x1000: two full bursts and a tail
        arready = 1'b1;
        b = hs_cyc.size();
        expect_ar(32'h0000_1000, 8'd15);
        expect_ar(32'h0000_1040, 8'd15);
        expect_ar(32'h0000_1080, 8'd7);
        start_xfer(32'h0000_1000, 14'd40);
        chk("busy_free", 32'(free), 32'd0);
        wait_done("done_40", 200);
        chk("start_latency", 32'(hs_cyc[b] - start_cyc), 32'd2);
        chk("b2b_gap", 32'(hs_cyc[b+1] - hs_cyc[b]), 32'd2);
        chk("done_after_rb", 32'(done_cyc - last_rb_cyc), 32'd1);
        chk("free_after", 32'(free), 32'd1);

        // Page split at 0x1000
        expect_ar(32'h0000_0FF0, 8'd3);
        expect_ar(32'h0000_1000, 8'd5);
        start_xfer(32'h0000_0FF0, 14'd10);
        wait_done("done_page", 100);

        // Second burst is the page-limited one
        expect_ar(32'h0000_1F88, 8'd15);
        expect_ar(32'h0000_1FC8, 8'd13);
        expect_ar(32'h0000_2000, 8'd9);
        start_xfer(32'h0000_1F88, 14'd40);
        wait_done("done_page2", 200);

        // Unaligned start address is truncated to the beat
        expect_ar(32'h0000_5004, 8'd2);
        start_xfer(32'h0000_5006, 14'd3);
        wait_done("done_unaligned", 100);

        // Outstanding limit of 2 with completions held off
        auto_rb = 1'b0;
        b = hs_count;
        for (int i = 0; i < 4; i++) expect_ar(32'h0000_2000 + 32'(i * 64), 8'd15);
        start_xfer(32'h0000_2000, 14'd64);
        repeat (20) step();
        @(negedge aclk);
        #1;
        chk("throttle_hs", 32'(hs_count - b), 32'd2);
        chk("throttle_arvalid", 32'(arvalid), 32'd0);
        step();
        man_pulse = 1'b1;
        step();
        man_pulse = 1'b0;
        repeat (4) step();
        chk("release_hs", 32'(hs_count - b), 32'd3);
        auto_rb = 1'b1;
        wait_done("done_throttle", 300);

        // arready stalled for 5 cycles
        arready = 1'b0;
        expect_ar(32'h0000_3000, 8'd7);
        start_xfer(32'h0000_3000, 14'd8);
        wait_arvalid("stall_arvalid", 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_araddr", araddr, 32'h0000_3000);
            chk("stall_arlen", 32'(arlen), 32'd7);
        end
        step();
        arready = 1'b1;
        wait_done("done_stall", 100);

        // Zero-length transfer
        b = hs_count;
        start_xfer(32'h0000_8000, 14'd0);
        wait_done("done_zero", 10);
        chk("zero_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        chk("zero_no_ar", 32'(hs_count - b), 32'd0);
        chk("zero_free", 32'(free), 32'd1);
        step();
        chk("zero_done_low", 32'(done), 32'd0);

        // Asynchronous reset with arvalid high
        arready = 1'b0;
        start_xfer(32'h0000_6000, 14'd16);
        wait_arvalid("pre_reset_arvalid", 10);
        @(posedge aclk);
        #3;
        areset = 1'b0;
        #1;
        chk("async_arvalid", 32'(arvalid), 32'd0);
        chk("async_free", 32'(free), 32'd1);
        chk("async_araddr", araddr, 32'h0);
        exp_q.delete();
        rb_seen = hs_count;
        step();
        areset  = 1'b1;
        arready = 1'b1;
        expect_ar(32'h0000_7000, 8'd3);
        start_xfer(32'h0000_7000, 14'd4);
        wait_done("done_after_reset", 100);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
